// File: rtl/alu_ccr_ctrl.sv
// Condition-code register for the execute-stage ALU: selective flag update, jump
// evaluation with flag consume, and a shadow stack that saves/restores the CCR across interrupts.
module alu_ccr_ctrl #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [5:0] alu_fun,
  input  logic [3:0] alu_flags,
  input  logic       cond_valid,
  input  logic [1:0] cond_sel,
  input  logic       int_save,
  input  logic       int_restore,
  output logic [3:0] ccr,
  output logic       carry_in,
  output logic       branch_taken,
  output logic       shadow_full,
  output logic       shadow_err
);

  typedef enum logic [1:0] {
    SEL_Z   = 2'b00,
    SEL_N   = 2'b01,
    SEL_C   = 2'b10,
    SEL_JMP = 2'b11
  } cond_sel_e;

  localparam logic [3:0] MASK_ALL  = 4'b1111;
  localparam logic [3:0] MASK_ZN   = 4'b0011;
  localparam logic [3:0] MASK_C    = 4'b0100;
  localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

  logic [3:0]       ccr_q, ccr_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [3:0]       stack_q [DEPTH];
  logic [3:0]       stack_d [DEPTH];
  logic             err_q, err_d;

  logic [3:0] wr_mask, wr_val, clr_mask, ccr_exec, pop_val;
  logic       flag_hit, stack_empty, push_ok, pop_ok;
  cond_sel_e  sel;

  // Flag write mask per ALU function; SETC/CLRC force the carry value themselves.
  always_comb begin
    wr_mask = '0;
    wr_val  = alu_flags;
    unique case (alu_fun)
      6'd2, 6'd3, 6'd16, 6'd17: wr_mask = MASK_ALL;
      6'd5, 6'd14, 6'd15, 6'd22: wr_mask = MASK_ZN;
      6'd6, 6'd7:               wr_mask = MASK_C;
      6'd8: begin
        wr_mask   = MASK_C;
        wr_val[2] = 1'b1;
      end
      6'd9: begin
        wr_mask   = MASK_C;
        wr_val[2] = 1'b0;
      end
      default: wr_mask = '0;
    endcase
    if (!en) wr_mask = '0;
  end

  assign sel = cond_sel_e'(cond_sel);

  always_comb begin
    unique case (sel)
      SEL_Z:   flag_hit = ccr_q[0];
      SEL_N:   flag_hit = ccr_q[1];
      SEL_C:   flag_hit = ccr_q[2];
      default: flag_hit = 1'b1;
    endcase
  end

  assign branch_taken = reset & en & cond_valid & flag_hit;

  // Clear is applied before the ALU write so a same-cycle ALU write of the tested bit wins.
  always_comb begin
    clr_mask = '0;
    if (branch_taken && sel != SEL_JMP) clr_mask[cond_sel] = 1'b1;
    ccr_exec = ((ccr_q & ~clr_mask) & ~wr_mask) | (wr_val & wr_mask);
  end

  assign stack_empty = (ptr_q == '0);
  assign shadow_full = (ptr_q == PTR_FULL);
  assign push_ok     = int_save & ~int_restore & ~shadow_full;
  assign pop_ok      = int_restore & ~int_save & ~stack_empty;
  assign err_d       = (int_save & int_restore)
                     | (int_save & ~int_restore & shadow_full)
                     | (int_restore & ~int_save & stack_empty);

  always_comb begin
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q == PTR_W'(i + 1)) pop_val = stack_q[i];
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stack_d = stack_q;
    ptr_d   = ptr_q;
    ccr_d   = ccr_exec;
    if (push_ok) begin
      ptr_d = ptr_q + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (ptr_q == PTR_W'(i)) stack_d[i] = ccr_q;
      end
    end else if (pop_ok) begin
      ptr_d = ptr_q - 1'b1;
      ccr_d = pop_val;
    end
  end

  // NOTE: the shadow stack is only DEPTH entries and must read as zero after reset, so it is reset like any register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ccr_q <= '0;
      ptr_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      ccr_q   <= ccr_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign ccr        = ccr_q;
  assign carry_in   = ccr_q[2];
  assign shadow_err = err_q;

endmodule

// File: doc/alu_ccr_ctrl.md
Name: alu_ccr_ctrl

Overview:
Condition-code register (CCR) controller for the 8-bit ALU in the execute stage. It latches the ALU flag vector selectively per alu_fun and feeds the registered carry back to the ALU for RLC/RRC. It evaluates conditional jumps against the CCR and clears the consumed flag. It also saves and restores the CCR on interrupt entry and return through a small shadow stack.

Parameters:
DEPTH, 2, number of shadow-stack entries for nested interrupts (1..4)
PTR_W, 2, stack pointer width; must hold 0..DEPTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
en  input  1  execute stage valid and not stalled; gates ALU update and jump evaluation
alu_fun  input  6  ALU function code of the instruction in execute
alu_flags  input  4  ALU flags {V,C,N,Z} for the current instruction
cond_valid  input  1  conditional or unconditional jump in execute
cond_sel  input  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional)
int_save  input  1  interrupt entry; push CCR (single-cycle pulse)
int_restore  input  1  RTI; pop CCR (single-cycle pulse)
ccr  output  4  registered flags {V,C,N,Z}
carry_in  output  1  ccr[2], fed to the ALU carry input for RLC/RRC
branch_taken  output  1  combinational jump decision
shadow_full  output  1  stack holds DEPTH entries
shadow_err  output  1  registered one-cycle pulse on an illegal stack operation

Behaviour:
- Reset (reset=0, async): ccr=0, stack pointer=0, all stack entries=0, shadow_err=0. branch_taken is forced to 0 while reset is low.
- Update mask by alu_fun, applied at the clock edge when en=1:
  - 2 ADD, 3 SUB, 16 INC, 17 DEC: write Z, N, C and V.
  - 5 OR, 14 NOT, 15 NEG, 22 LOOP: write Z and N only.
  - 6 RLC, 7 RRC, 8 SETC, 9 CLRC: write C only.
  - Any other code: no write.
  - Unmasked bits hold their value.
- Latency: ccr reflects an instruction's flags on the cycle after its en=1 edge.
- branch_taken = reset & en & cond_valid & (cond_sel==11 | selected flag). The selected flag is Z, N or C, read from the registered ccr.
- Jump flag consume: when a JZ, JN or JC is taken, the tested flag clears at the same edge. JMP clears nothing.
- Jump clear vs ALU write in the same cycle: if the ALU mask writes the tested bit, the ALU write wins.
- int_save (push): stores the pre-edge ccr at the current pointer and increments the pointer.
  - Any ALU update or jump clear in that cycle still applies to ccr.
- int_restore (pop): decrements the pointer and loads ccr from the popped entry.
  - The pop overrides every ALU update and jump clear in that cycle.
- shadow_err pulses for one cycle in three cases, and the offending operation is discarded (no pointer or ccr change from it):
  - push while full;
  - pop while empty;
  - int_save and int_restore both high in the same cycle.
- shadow_full = (pointer == DEPTH), derived combinationally from the registered pointer.
- Reset asserted mid-sequence: all state returns to reset values immediately; no pending operation completes.

Test Plan:
- Reset, then en=1, alu_fun=2, alu_flags=4'b1101 -> next cycle ccr=4'b1101 and carry_in=1. Then alu_fun=5, alu_flags=4'b0010 -> ccr=4'b1110 (V and C held).
- ccr=4'b0001, en=1, cond_valid=1, cond_sel=00, alu_fun=0 -> branch_taken=1 that cycle; next cycle ccr=4'b0000. Repeat with cond_sel=01 and N=0 -> branch_taken=0, ccr unchanged.
- Same-cycle conflict: ccr=4'b0100, JC taken while alu_fun=8 (SETC), alu_flags=4'b0000 -> branch_taken=1, ccr stays 4'b0100 (ALU write wins over the jump clear).
- Nested interrupts, DEPTH=2:
  - ccr=4'b0011, int_save; then ccr set to 4'b1000 via alu_fun=2, int_save -> shadow_full=1.
  - Third int_save -> shadow_err pulses for one cycle, pointer unchanged.
  - Two int_restore pulses -> ccr=4'b1000, then 4'b0011.
  - Third int_restore -> shadow_err pulse, ccr unchanged.
- int_save and int_restore high together with one entry on the stack -> shadow_err pulse, pointer and ccr unchanged.
- Mid-sequence reset: one entry pushed and ccr=4'b1111, then reset pulsed low between edges -> ccr=0, shadow_full=0 and shadow_err=0 immediately. A following int_restore gives shadow_err (stack empty).
